ysyx_25030081_idu: RTL and testbench
====================================

// Module: ysyx_25030081_idu
// PURPOSE
//  Registered RV32I instruction-decode stage for the NPC core. Takes {pc,inst} from IFU over valid/ready, decodes
//  the full control bundle (fixed and illegal-flagged), and presents it to EXU over valid/ready through a
//  2-entry skid buffer. Supports flush and counts retired decodes. Optional RV32M decode.
// PARAMETERS
//  PC_W      32  width of pc path
//  ALUOP_W   5   alu_op width (>=5 required when M decode compiled in)
//  CNT_W     32  width of decode_cnt (wraps)
// PORTS
//  clock      in   1        rising-edge clock
//  reset_n    in   1        synchronous active-low reset
//  flush      in   1        discard all buffered and incoming instructions
//  in_valid   in   1        IFU offers {in_pc,in_inst}
//  in_ready   out  1        IDU accepts this cycle
//  in_pc      in   PC_W     instruction address
//  in_inst    in   32       instruction word
//  out_valid  out  1        decoded bundle valid
//  out_ready  in   1        EXU accepts bundle
//  out_pc/out_inst out PC_W/32  pass-through of head entry
//  ext_op     out  3        imm type: 0 I,1 S,2 B,3 U,4 J
//  reg_wr     out  1        write rd
//  alu_a_src  out  1        0 rs1, 1 pc
//  alu_b_src  out  2        0 rs2, 1 imm, 2 const 4
//  alu_op     out  ALUOP_W  0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,10 passB; 16-23 M ops
//  branch     out  4        0 none,1 jal,2 jalr,{1,funct3} for B-type
//  mem_to_reg/mem_ren/mem_wen out 1 each  load writeback / load / store
//  mem_op     out  3        funct3 of load/store, else 0
//  illegal    out  1        undecodable instruction
//  ebreak     out  1        inst == 32'h0010_0073
//  decode_cnt out  CNT_W    bundles handed to EXU
// BEHAVIOUR
//  - Decode is combinational on in_inst, captured at acceptance; outputs are pure register reads (no comb in->out).
//  - Buffer FSM: EMPTY -> ONE on accept; ONE -> TWO on accept without out fire; TWO -> ONE on out fire w/o accept;
//    ONE -> EMPTY on out fire w/o accept; accept+fire in ONE stays ONE (head replaced). in_ready = (state!=TWO), registered.
//  - Latency: accepted in cycle N -> out_valid in cycle N+1 when EMPTY. Ordering strictly FIFO; skid entry moves to head on fire.
//  - out fire = out_valid & out_ready; accept = in_valid & in_ready & !flush.
//  - flush: next edge state=EMPTY, any same-cycle input dropped; same-cycle out fire still counted.
//  - Decode: R/I ALU, loads, stores, branches, lui (alu passB, b imm), auipc (a pc, b imm), jal/jalr (a pc, b 4, reg_wr).
//    slli/srli need funct7=0, srai funct7=0100000; R ops need listed funct7; loads funct3 in {0,1,2,4,5}; stores {0,1,2}.
//  - illegal=1 forces reg_wr, mem_ren, mem_wen, branch to 0; ebreak is legal, no writeback.
//  - decode_cnt += 1 per out fire, wraps 2^CNT_W-1 -> 0.
//  - reset_n low at an edge: state EMPTY, all outputs 0, decode_cnt 0; in_ready 0 while reset_n low, 1 the cycle after.
//    Reset mid-transfer drops both entries.
// CONFIGURATION
//  YSYX_25030081_IDU_RV32M_EN defined: opcode 0110011 funct7=0000001 decodes to alu_op 16+funct3, reg_wr=1.
//  Undefined: those encodings raise illegal; ALUOP_W may be 4.
// TESTING
//  reset_n=0 2 cycles -> all outputs 0, in_ready=0; release -> in_ready=1, decode_cnt=0.
//  in 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid, alu_op=0, alu_b_src=1, ext_op=0, reg_wr=1.
//  out_ready=0, feed 3 insts back-to-back -> in_ready low after 2nd; release -> 3 bundles in order, decode_cnt=3.
//  0xFE000EE3 (beq) -> branch=4'b1000, ext_op=2, reg_wr=0; 0x0000006F (jal) -> branch=1, alu_b_src=2, ext_op=4.
//  0x40105013 legal srai; 0x02208033 (mul) -> illegal=1 without macro, alu_op=16 with macro.
//  state TWO + flush with in_valid=1 -> next cycle out_valid=0, dropped inst never appears; CNT_W=2 after 4 fires -> 0.

Source files
------------

// File: rtl/ysyx_25030081_idu.sv
// RV32I decode stage: captures decoded {pc,inst} into a 2-entry skid buffer and presents it to EXU.
// Define YSYX_25030081_IDU_RV32M_EN to also decode the RV32M multiply/divide group.
module ysyx_25030081_idu #(
    parameter int PC_W    = 32,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [31:0]        in_inst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [31:0]        out_inst,
    output logic [2:0]         ext_op,
    output logic               reg_wr,
    output logic               alu_a_src,
    output logic [1:0]         alu_b_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         branch,
    output logic               mem_to_reg,
    output logic               mem_ren,
    output logic               mem_wen,
    output logic [2:0]         mem_op,
    output logic               illegal,
    output logic               ebreak,
    output logic [CNT_W-1:0]   decode_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] EXT_I = 3'd0;
    localparam logic [2:0] EXT_S = 3'd1;
    localparam logic [2:0] EXT_B = 3'd2;
    localparam logic [2:0] EXT_U = 3'd3;
    localparam logic [2:0] EXT_J = 3'd4;

    localparam logic [1:0] B_RS2 = 2'd0;
    localparam logic [1:0] B_IMM = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(10);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    typedef struct packed {
        logic [2:0]         ext_op;
        logic               reg_wr;
        logic               alu_a_src;
        logic [1:0]         alu_b_src;
        logic [ALUOP_W-1:0] alu_op;
        logic [3:0]         branch;
        logic               mem_to_reg;
        logic               mem_ren;
        logic               mem_wen;
        logic [2:0]         mem_op;
        logic               illegal;
        logic               ebreak;
    } ctl_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        ctl_t            ctl;
    } entry_t;

    state_t     state, state_nxt;
    entry_t     head, skid, incoming;
    ctl_t       dec;
    logic       legal, accept, fire;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    assign accept = in_valid & in_ready & ~flush;
    assign fire   = out_valid & out_ready;

    // Shared funct3 -> ALU op map for OP and OP-IMM; `alt` selects sub/sra.
    function automatic logic [ALUOP_W-1:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALUOP_W'(2);
            3'd2:    return ALUOP_W'(3);
            3'd3:    return ALUOP_W'(4);
            3'd4:    return ALUOP_W'(5);
            3'd5:    return alt ? ALUOP_W'(7) : ALUOP_W'(6);
            3'd6:    return ALUOP_W'(8);
            default: return ALUOP_W'(9);
        endcase
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves a latch behind.
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OP_LUI: begin
                dec.ext_op    = EXT_U;
                dec.reg_wr    = 1'b1;
                dec.alu_b_src = B_IMM;
                dec.alu_op    = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.ext_op    = EXT_U;
                dec.reg_wr    = 1'b1;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = B_IMM;
            end
            OP_JAL, OP_JALR: begin
                legal         = (opcode == OP_JAL) || (funct3 == 3'd0);
                dec.ext_op    = (opcode == OP_JAL) ? EXT_J : EXT_I;
                dec.reg_wr    = 1'b1;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = B_FOUR;
                dec.branch    = (opcode == OP_JAL) ? 4'd1 : 4'd2;
            end
            OP_BRANCH: begin
                // Comparison is done by subtracting rs2 from rs1.
                legal       = (funct3 != 3'd2) && (funct3 != 3'd3);
                dec.ext_op  = EXT_B;
                dec.alu_op  = ALU_SUB;
                dec.branch  = {1'b1, funct3};
            end
            OP_LOAD: begin
                legal          = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
                dec.reg_wr     = 1'b1;
                dec.alu_b_src  = B_IMM;
                dec.mem_to_reg = 1'b1;
                dec.mem_ren    = 1'b1;
                dec.mem_op     = funct3;
            end
            OP_STORE: begin
                legal         = (funct3 <= 3'd2);
                dec.ext_op    = EXT_S;
                dec.alu_b_src = B_IMM;
                dec.mem_wen   = 1'b1;
                dec.mem_op    = funct3;
            end
            OP_IMM: begin
                if (funct3 == 3'd1)      legal = (funct7 == 7'h00);
                else if (funct3 == 3'd5) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                dec.reg_wr    = 1'b1;
                dec.alu_b_src = B_IMM;
                dec.alu_op    = alu_of(funct3, (funct3 == 3'd5) && in_inst[30]);
            end
            OP_REG: begin
                dec.reg_wr = 1'b1;
                if (funct7 == 7'h00) begin
                    dec.alu_op = alu_of(funct3, 1'b0);
                end else if (funct7 == 7'h20) begin
                    legal      = (funct3 == 3'd0) || (funct3 == 3'd5);
                    dec.alu_op = alu_of(funct3, 1'b1);
`ifdef YSYX_25030081_IDU_RV32M_EN
                end else if (funct7 == 7'h01) begin
                    dec.alu_op = ALUOP_W'({2'b10, funct3});
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            OP_SYSTEM: begin
                legal      = (in_inst == 32'h0010_0073);
                dec.ebreak = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // An undecodable word carries no side effects downstream.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign incoming = '{pc: in_pc, inst: in_inst, ctl: dec};

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (accept) state_nxt = S_ONE;
                S_ONE: begin
                    if (accept && !fire)      state_nxt = S_TWO;
                    else if (!accept && fire) state_nxt = S_EMPTY;
                end
                S_TWO:   if (fire) state_nxt = S_ONE;
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: buffer entries are reset too because their fields drive the outputs directly.
            state      <= S_EMPTY;
            head       <= '0;
            skid       <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
            decode_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state     <= state_nxt;
            out_valid <= (state_nxt != S_EMPTY);
            in_ready  <= (state_nxt != S_TWO);
            if (fire) decode_cnt <= decode_cnt + CNT_W'(1);
            if (state == S_TWO && fire)
                head <= skid;
            else if (accept && (state == S_EMPTY || fire))
                head <= incoming;
            if (accept && state == S_ONE && !fire)
                skid <= incoming;
        end
    end

    assign out_pc     = head.pc;
    assign out_inst   = head.inst;
    assign ext_op     = head.ctl.ext_op;
    assign reg_wr     = head.ctl.reg_wr;
    assign alu_a_src  = head.ctl.alu_a_src;
    assign alu_b_src  = head.ctl.alu_b_src;
    assign alu_op     = head.ctl.alu_op;
    assign branch     = head.ctl.branch;
    assign mem_to_reg = head.ctl.mem_to_reg;
    assign mem_ren    = head.ctl.mem_ren;
    assign mem_wen    = head.ctl.mem_wen;
    assign mem_op     = head.ctl.mem_op;
    assign illegal    = head.ctl.illegal;
    assign ebreak     = head.ctl.ebreak;

endmodule

// File: tb/tb_ysyx_25030081_idu.sv
// Scoreboard bench for ysyx_25030081_idu: a driver pushes expected bundles on accept, a monitor pops on fire.
// The reference decoder honours YSYX_25030081_IDU_RV32M_EN the same way the design does.
module tb_ysyx_25030081_idu;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic [2:0] ext_op;
        logic       reg_wr;
        logic       a_src;
        logic [1:0] b_src;
        logic [4:0] alu_op;
        logic [3:0] branch;
        logic       m2r;
        logic       ren;
        logic       wen;
        logic [2:0] mem_op;
        logic       illegal;
        logic       ebreak;
    } ctl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        ctl_t        ctl;
    } exp_t;

    localparam logic [6:0] OPCS [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                                         7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    localparam logic [6:0] F7S  [4]  = '{7'h00, 7'h20, 7'h01, 7'h7f};
    // add, sll, slt, sltu, xor, srl, or, and indexed by funct3
    localparam logic [4:0] F3_ALU [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};

    logic        clock, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_inst, out_pc, out_inst;
    logic [2:0]  ext_op, mem_op;
    logic        reg_wr, alu_a_src, mem_to_reg, mem_ren, mem_wen, illegal, ebreak;
    logic [1:0]  alu_b_src;
    logic [4:0]  alu_op;
    logic [3:0]  branch;
    logic [CNT_W-1:0] decode_cnt;

    exp_t q[$];
    int   n_vec = 0, n_miss = 0, exp_cnt = 0;
    bit   mon_en = 0, rst_prev = 1, last_acc;
    logic [31:0] pc_ctr = 32'h8000_0000;

    ysyx_25030081_idu #(.PC_W(32), .ALUOP_W(5), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .ext_op(ext_op), .reg_wr(reg_wr), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
        .alu_op(alu_op), .branch(branch), .mem_to_reg(mem_to_reg), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_op(mem_op), .illegal(illegal), .ebreak(ebreak),
        .decode_cnt(decode_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decoder written from the instruction-set rules.
    function automatic ctl_t ref_decode(input logic [31:0] i);
        ctl_t       c;
        bit         ok;
        logic [2:0] f3;
        logic [6:0] f7;
        c  = '0;
        ok = 1;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            7'h37: begin c.ext_op = 3'd3; c.reg_wr = 1; c.b_src = 2'd1; c.alu_op = 5'd10; end
            7'h17: begin c.ext_op = 3'd3; c.reg_wr = 1; c.a_src = 1; c.b_src = 2'd1; end
            7'h6f: begin c.ext_op = 3'd4; c.reg_wr = 1; c.a_src = 1; c.b_src = 2'd2; c.branch = 4'd1; end
            7'h67: begin
                ok = (f3 == 0);
                c.reg_wr = 1; c.a_src = 1; c.b_src = 2'd2; c.branch = 4'd2;
            end
            7'h63: begin
                ok = !(f3 inside {3'd2, 3'd3});
                c.ext_op = 3'd2; c.alu_op = 5'd1; c.branch = 4'd8 + {1'b0, f3};
            end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                c.reg_wr = 1; c.b_src = 2'd1; c.m2r = 1; c.ren = 1; c.mem_op = f3;
            end
            7'h23: begin
                ok = (f3 <= 3'd2);
                c.ext_op = 3'd1; c.b_src = 2'd1; c.wen = 1; c.mem_op = f3;
            end
            7'h13: begin
                c.reg_wr = 1; c.b_src = 2'd1; c.alu_op = F3_ALU[f3];
                if (f3 == 3'd1) ok = (f7 == 0);
                if (f3 == 3'd5) begin
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) c.alu_op = 5'd7;
                end
            end
            7'h33: begin
                c.reg_wr = 1;
                if (f7 == 7'h00) c.alu_op = F3_ALU[f3];
                else if (f7 == 7'h20) begin
                    ok = (f3 == 3'd0) || (f3 == 3'd5);
                    c.alu_op = (f3 == 3'd0) ? 5'd1 : 5'd7;
                end
`ifdef YSYX_25030081_IDU_RV32M_EN
                else if (f7 == 7'h01) c.alu_op = 5'd16 + {2'b00, f3};
`endif
                else ok = 0;
            end
            7'h73: begin ok = (i == 32'h0010_0073); c.ebreak = 1; end
            default: ok = 0;
        endcase
        if (!ok) begin
            c = '0;
            c.illegal = 1;
        end
        return c;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0) return 32'h0010_0073;
        if (sel == 1) return r;
        r[6:0]   = OPCS[$urandom_range(0, 9)];
        r[31:25] = F7S[$urandom_range(0, 3)];
        return r;
    endfunction

    // One cycle of stimulus; the expected bundle is queued when the DUT takes the instruction.
    task automatic step(input logic v, input logic [31:0] inst, input logic ordy,
                        input logic fl, input logic rn);
        @(negedge clock);
        in_valid  = v;
        in_pc     = pc_ctr;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        reset_n   = rn;
        #2;
        last_acc = rn && v && (in_ready === 1'b1) && !fl;
        if (last_acc) begin
            q.push_back('{pc: pc_ctr, inst: inst, ctl: ref_decode(inst)});
            pc_ctr += 32'd4;
        end
    endtask

    task automatic send(input logic [31:0] inst);
        step(1, inst, 1, 0, 1);
        step(0, 32'h0, 1, 0, 1);
    endtask

    // Monitor: checks handshake state every cycle and pops the scoreboard on every fire.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (mon_en) begin
                if (!reset_n) begin
                    q.delete();
                    exp_cnt  = 0;
                    rst_prev = 1;
                end else begin
                    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
                    check("in_ready", 64'(in_ready), 64'(!rst_prev && q.size() < 2));
                    check("decode_cnt", 64'(decode_cnt), 64'(exp_cnt % (1 << CNT_W)));
                    if (out_valid === 1'b1 && out_ready) begin
                        check("fifo_nonempty", 64'(q.size() != 0), 64'(1));
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            check("out_pc", 64'(out_pc), 64'(e.pc));
                            check("out_inst", 64'(out_inst), 64'(e.inst));
                            check("ext_op", 64'(ext_op), 64'(e.ctl.ext_op));
                            check("reg_wr", 64'(reg_wr), 64'(e.ctl.reg_wr));
                            check("alu_a_src", 64'(alu_a_src), 64'(e.ctl.a_src));
                            check("alu_b_src", 64'(alu_b_src), 64'(e.ctl.b_src));
                            check("alu_op", 64'(alu_op), 64'(e.ctl.alu_op));
                            check("branch", 64'(branch), 64'(e.ctl.branch));
                            check("mem_to_reg", 64'(mem_to_reg), 64'(e.ctl.m2r));
                            check("mem_ren", 64'(mem_ren), 64'(e.ctl.ren));
                            check("mem_wen", 64'(mem_wen), 64'(e.ctl.wen));
                            check("mem_op", 64'(mem_op), 64'(e.ctl.mem_op));
                            check("illegal", 64'(illegal), 64'(e.ctl.illegal));
                            check("ebreak", 64'(ebreak), 64'(e.ctl.ebreak));
                        end
                        exp_cnt++;
                    end
                    if (flush) q.delete();
                    rst_prev = 0;
                end
            end
        end
    end

    initial begin
        int  waited;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_inst   = '0;

        // Reset held for two edges: everything reads zero.
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_decode_cnt", 64'(decode_cnt), 64'(0));
        check("rst_bundle", 64'({alu_op, branch, reg_wr, illegal, ebreak, mem_wen}), 64'(0));
        check("rst_out_inst", 64'(out_inst), 64'(0));
        mon_en = 1;
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 1);
        check("rel_in_ready", 64'(in_ready), 64'(1));
        check("rel_decode_cnt", 64'(decode_cnt), 64'(0));

        // Back-pressure: two entries fill the buffer, the third waits.
        step(1, 32'h0010_0093, 0, 0, 1);
        step(1, 32'h0020_0113, 0, 0, 1);
        step(1, 32'h0030_0193, 0, 0, 1);
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_third_held", 64'(last_acc), 64'(0));
        waited = 0;
        do begin
            step(1, 32'h0030_0193, 1, 0, 1);
            waited++;
        end while (!last_acc && waited < 10);
        check("bp_third_accepted", 64'(last_acc), 64'(1));
        waited = 0;
        while (q.size() != 0 && waited < 10) begin
            step(0, 32'h0, 1, 0, 1);
            waited++;
        end
        check("bp_drained", 64'(q.size()), 64'(0));
        step(0, 32'h0, 1, 0, 1);
        check("bp_decode_cnt", 64'(decode_cnt), 64'(3));

        // Directed decodes; the fourth fire wraps the 2-bit counter.
        send(32'h0050_0093);
        check("addi_valid", 64'(out_valid), 64'(1));
        check("addi_alu_op", 64'(alu_op), 64'(0));
        check("addi_b_src", 64'(alu_b_src), 64'(1));
        check("addi_ext_op", 64'(ext_op), 64'(0));
        check("addi_reg_wr", 64'(reg_wr), 64'(1));
        step(0, 32'h0, 1, 0, 1);
        check("cnt_wrap", 64'(decode_cnt), 64'(0));
        send(32'hFE00_0EE3);
        check("beq_branch", 64'(branch), 64'(4'b1000));
        check("beq_ext_op", 64'(ext_op), 64'(2));
        check("beq_reg_wr", 64'(reg_wr), 64'(0));
        send(32'h0000_006F);
        check("jal_branch", 64'(branch), 64'(1));
        check("jal_b_src", 64'(alu_b_src), 64'(2));
        check("jal_ext_op", 64'(ext_op), 64'(4));
        send(32'h4010_5013);
        check("srai_legal", 64'(illegal), 64'(0));
        check("srai_alu_op", 64'(alu_op), 64'(7));
        send(32'h0220_8033);
`ifdef YSYX_25030081_IDU_RV32M_EN
        check("mul_legal", 64'(illegal), 64'(0));
        check("mul_alu_op", 64'(alu_op), 64'(16));
`else
        check("mul_illegal", 64'(illegal), 64'(1));
        check("mul_reg_wr", 64'(reg_wr), 64'(0));
`endif
        send(32'h0010_0073);
        check("ebreak_flag", 64'(ebreak), 64'(1));
        check("ebreak_reg_wr", 64'(reg_wr), 64'(0));

        // Flush with a full buffer and a new instruction offered in the same cycle.
        step(0, 32'h0, 1, 0, 1);
        step(1, 32'h0040_0213, 0, 0, 1);
        step(1, 32'h0050_0293, 0, 0, 1);
        step(1, 32'h0060_0313, 0, 1, 1);
        check("flush_dropped_input", 64'(last_acc), 64'(0));
        step(0, 32'h0, 1, 0, 1);
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        repeat (3) step(0, 32'h0, 1, 0, 1);

        // Randomized traffic with occasional flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 399) != 0);
        end
        waited = 0;
        while (q.size() != 0 && waited < 10) begin
            step(0, 32'h0, 1, 0, 1);
            waited++;
        end
        check("final_drained", 64'(q.size()), 64'(0));
        step(0, 32'h0, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
